// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// Opcode/zero flow into the controller; every datapath control flows out.
interface multicycle_ctrl_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
);
  logic [OP_W-1:0]    opcode;
  logic               zero;
  logic               PCWre;
  logic [1:0]         PCSrc;
  logic               IRWre;
  logic               InsMemRW;
  logic               RegWre;
  logic [1:0]         RegOut;
  logic               WrRegData;
  logic               ALUSrcA;
  logic               ALUSrcB;
  logic               ALUM2Reg;
  logic               DataMemRW;
  logic               ExtSel;
  logic [ALUOP_W-1:0] ALUOp;
  logic [2:0]         state;

  modport master (
    input  opcode, zero,
    output PCWre, PCSrc, IRWre, InsMemRW,
    output RegWre, RegOut, WrRegData,
    output ALUSrcA, ALUSrcB, ALUM2Reg,
    output DataMemRW, ExtSel, ALUOp, state
  );

  modport slave (
    output opcode, zero,
    input  PCWre, PCSrc, IRWre, InsMemRW,
    input  RegWre, RegOut, WrRegData,
    input  ALUSrcA, ALUSrcB, ALUM2Reg,
    input  DataMemRW, ExtSel, ALUOp, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM feeding the PC register and datapath.
// Optional bne support is enabled by defining MC_BNE_EN.
module multicycle_ctrl #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic CLK,
  input  logic RST,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'b010000);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b010001);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b010010);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(6'b011000);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b110001);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b110100);
`ifdef MC_BNE_EN
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b110101);
`endif
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b111000);
  localparam logic [OP_W-1:0] OP_JR   = OP_W'(6'b111001);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b111010);

  localparam logic [ALUOP_W-1:0] A_ADD = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] A_SUB = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] A_SLL = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] A_OR  = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] A_AND = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] A_SLT = ALUOP_W'(3'b101);

  state_t st, nxt;

  logic [ALUOP_W-1:0] alu_op;
  logic alu_ins, r_type, imm, shamt, zext;
  logic ls, is_sw, br, bne, jmp, jr, link;

  always_comb begin
    alu_op  = A_ADD;
    alu_ins = 1'b0;
    r_type  = 1'b0;
    imm     = 1'b0;
    shamt   = 1'b0;
    zext    = 1'b0;
    ls      = 1'b0;
    is_sw   = 1'b0;
    br      = 1'b0;
    bne     = 1'b0;
    jmp     = 1'b0;
    jr      = 1'b0;
    link    = 1'b0;
    case (bus.opcode)
      OP_ADD:  begin alu_ins = 1'b1; r_type = 1'b1; end
      OP_SUB:  begin alu_ins = 1'b1; r_type = 1'b1; alu_op = A_SUB; end
      OP_ADDI: begin alu_ins = 1'b1; imm = 1'b1; end
      OP_OR:   begin alu_ins = 1'b1; r_type = 1'b1; alu_op = A_OR; end
      OP_AND:  begin alu_ins = 1'b1; r_type = 1'b1; alu_op = A_AND; end
      OP_ORI:  begin
        alu_ins = 1'b1; imm = 1'b1; zext = 1'b1; alu_op = A_OR;
      end
      OP_SLL:  begin
        alu_ins = 1'b1; r_type = 1'b1; shamt = 1'b1; alu_op = A_SLL;
      end
      OP_SLT:  begin alu_ins = 1'b1; r_type = 1'b1; alu_op = A_SLT; end
      OP_SW:   begin ls = 1'b1; imm = 1'b1; is_sw = 1'b1; end
      OP_LW:   begin ls = 1'b1; imm = 1'b1; end
      OP_BEQ:  begin br = 1'b1; alu_op = A_SUB; end
`ifdef MC_BNE_EN
      OP_BNE:  begin br = 1'b1; bne = 1'b1; alu_op = A_SUB; end
`endif
      OP_J:    jmp = 1'b1;
      OP_JAL:  begin jmp = 1'b1; link = 1'b1; end
      OP_JR:   jr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) st <= S_IF;
    else      st <= nxt;
  end

  always_comb begin
    nxt           = S_IF;
    bus.PCWre     = 1'b0;
    bus.PCSrc     = 2'b00;
    bus.IRWre     = 1'b0;
    bus.InsMemRW  = 1'b0;
    bus.RegWre    = 1'b0;
    bus.RegOut    = 2'b00;
    bus.WrRegData = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 1'b0;
    bus.ALUM2Reg  = 1'b0;
    bus.DataMemRW = 1'b0;
    bus.ExtSel    = 1'b0;
    bus.ALUOp     = '0;
    // Datapath selects stay stable for the whole EXE..WB window
    if (st != S_IF) bus.ExtSel = ~zext;
    if (st != S_IF && st != S_ID) begin
      bus.ALUOp     = alu_op;
      bus.ALUSrcA   = shamt;
      bus.ALUSrcB   = imm;
      bus.RegOut    = r_type ? 2'b10 : 2'b01;
      bus.WrRegData = 1'b1;
    end
    unique case (st)
      S_IF: begin
        bus.IRWre    = 1'b1;
        bus.InsMemRW = 1'b1;
        nxt          = S_ID;
      end
      S_ID: begin
        if (alu_ins)  nxt = S_EXE_AL;
        else if (br)  nxt = S_EXE_BR;
        else if (ls)  nxt = S_EXE_LS;
        else begin
          // halt holds the PC so it is refetched until reset
          bus.PCWre  = (bus.opcode != OP_W'(6'b111111));
          bus.RegWre = link;
          if (jmp)     bus.PCSrc = 2'b11;
          else if (jr) bus.PCSrc = 2'b10;
        end
      end
      S_EXE_AL: nxt = S_WB_AL;
      S_WB_AL: begin
        bus.PCWre  = 1'b1;
        bus.RegWre = 1'b1;
      end
      S_EXE_BR: begin
        bus.PCWre = 1'b1;
        if (bus.zero ^ bne) bus.PCSrc = 2'b01;
      end
      S_EXE_LS: nxt = S_MEM;
      S_MEM: begin
        if (is_sw) begin
          bus.DataMemRW = 1'b1;
          bus.PCWre     = 1'b1;
        end else begin
          nxt = S_WB_LD;
        end
      end
      S_WB_LD: begin
        bus.PCWre    = 1'b1;
        bus.RegWre   = 1'b1;
        bus.ALUM2Reg = 1'b1;
      end
    endcase
  end

  assign bus.state = st;

endmodule
